// File: rtl/cond_flag_unit.sv
// NZCV flags register plus a condition-code evaluator with a single-entry result buffer.
// Define COND_FLAG_OVF_COUNT_EN to build the saturating overflow-write counter.
module cond_flag_unit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       flags_in,
    input  logic             flags_we,
    input  logic             cond_valid,
    input  logic [3:0]       cond,
    output logic             cond_ready,
    output logic             pass_valid,
    output logic             pass,
    input  logic             pass_ready,
    output logic [3:0]       flags_q,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_count
);
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic       r_state;
    logic       r_pass;
    logic [3:0] r_flags;
    logic       w_accept;
    logic       w_eval;
    logic       w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Ready is gated by reset so nothing is accepted while the unit is held in reset.
    assign cond_ready = rst_n & ((r_state == ST_EMPTY) | pass_ready);
    assign w_accept   = cond_valid & cond_ready;

    always_comb begin
        w_eval = 1'b0;
        case (cond)
            4'd0:  w_eval = w_z;
            4'd1:  w_eval = ~w_z;
            4'd2:  w_eval = w_c;
            4'd3:  w_eval = ~w_c;
            4'd4:  w_eval = w_n;
            4'd5:  w_eval = ~w_n;
            4'd6:  w_eval = w_v;
            4'd7:  w_eval = ~w_v;
            4'd8:  w_eval = w_c & ~w_z;
            4'd9:  w_eval = ~w_c | w_z;
            4'd10: w_eval = (w_n == w_v);
            4'd11: w_eval = (w_n != w_v);
            4'd12: w_eval = ~w_z & (w_n == w_v);
            4'd13: w_eval = w_z | (w_n != w_v);
            4'd14: w_eval = 1'b1;
            default: w_eval = 1'b0;
        endcase
    end

    // Evaluation reads r_flags before any same-cycle write lands: no bypass.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_pass  <= 1'b0;
            r_flags <= 4'b0000;
        end else begin
            if (flags_we)
                r_flags <= flags_in;
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_FULL;
                        r_pass  <= w_eval;
                    end
                end
                default: begin
                    if (w_accept)
                        r_pass <= w_eval;
                    else if (pass_ready)
                        r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    assign pass_valid = (r_state == ST_FULL);
    assign pass       = r_pass;
    assign flags_q    = r_flags;

`ifdef COND_FLAG_OVF_COUNT_EN
    logic [CNT_W-1:0] r_ovf_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || ovf_clr)
            r_ovf_cnt <= '0;
        else if (flags_we && flags_in[0] && (r_ovf_cnt != {CNT_W{1'b1}}))
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end

    assign ovf_count = r_ovf_cnt;
`else
    logic w_unused_ovf_clr;
    assign w_unused_ovf_clr = ovf_clr;
    assign ovf_count        = '0;
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed + random bench for cond_flag_unit against a transaction-level reference model.
module tb_cond_flag_unit;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n, flags_we, cond_valid, pass_ready, ovf_clr;
    logic [3:0]       flags_in, cond;
    logic             cond_ready, pass_valid, pass;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] ovf_count;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    bit [3:0] m_flags = 4'h0;
    bit       m_full  = 1'b0;
    bit       m_pass  = 1'b0;
    int       m_cnt   = 0;

    always #5 clk = ~clk;

    cond_flag_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flags_in(flags_in), .flags_we(flags_we),
        .cond_valid(cond_valid), .cond(cond), .cond_ready(cond_ready),
        .pass_valid(pass_valid), .pass(pass), .pass_ready(pass_ready),
        .flags_q(flags_q), .ovf_clr(ovf_clr), .ovf_count(ovf_count)
    );

    // Conditions come in pairs; odd codes are the negation of the even one below.
    function automatic bit model_eval(bit [3:0] f, bit [3:0] c);
        bit n, z, cy, v, b;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        return c[0] ? !b : b;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check ready, clock, update model, check state.
    task automatic step(bit rst, bit fwe, bit [3:0] fin, bit cv, bit [3:0] c, bit pr, bit clr);
        bit exp_ready, acc;
        rst_n = rst; flags_we = fwe; flags_in = fin;
        cond_valid = cv; cond = c; pass_ready = pr; ovf_clr = clr;
        #1;
        exp_ready = rst && (!m_full || pr);
        chk("cond_ready", cond_ready, exp_ready);
        acc = cv && exp_ready;
        if (!rst) begin
            m_flags = 4'h0; m_full = 1'b0; m_pass = 1'b0; m_cnt = 0;
        end else begin
            if (acc) begin
                m_full = 1'b1;
                m_pass = model_eval(m_flags, c);
            end else if (m_full && pr) begin
                m_full = 1'b0;
            end
            if (fwe) m_flags = fin;
`ifdef COND_FLAG_OVF_COUNT_EN
            if (clr) m_cnt = 0;
            else if (fwe && fin[0] && m_cnt < CMAX) m_cnt++;
`endif
        end
        @(posedge clk);
        #1;
        chk("pass_valid", pass_valid, m_full);
        if (m_full || !rst) chk("pass", pass, m_pass);
        chk("flags_q", flags_q, m_flags);
        chk("ovf_count", ovf_count, m_cnt);
    endtask

    initial begin
        // reset
        step(0, 0, 4'h0, 0, 4'h0, 0, 0);
        step(0, 1, 4'hF, 1, 4'hE, 1, 0);
        chk("reset_flags", flags_q, 0);
        chk("reset_valid", pass_valid, 0);

        // Z set, EQ then NE
        step(1, 1, 4'b0100, 0, 4'h0, 1, 0);
        step(1, 0, 4'h0, 1, 4'd0, 1, 0);
        chk("eq_pass", pass, 1);
        step(1, 0, 4'h0, 1, 4'd1, 1, 0);
        chk("ne_pass", pass, 0);

        // N=1, V=0: GE LT GT LE back to back
        step(1, 1, 4'b1000, 0, 4'h0, 1, 0);
        step(1, 0, 4'h0, 1, 4'd10, 1, 0); chk("ge", pass, 0);
        step(1, 0, 4'h0, 1, 4'd11, 1, 0); chk("lt", pass, 1);
        step(1, 0, 4'h0, 1, 4'd12, 1, 0); chk("gt", pass, 0);
        step(1, 0, 4'h0, 1, 4'd13, 1, 0); chk("le", pass, 1);

        // stall with pass=1, flags writes must not disturb the buffered result
        step(1, 0, 4'h0, 1, 4'd14, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 4'(i), 1, 4'd15, 0, 0);
            chk("stall_pass", pass, 1);
        end
        step(1, 0, 4'h0, 1, 4'd15, 1, 0);
        chk("stall_release", pass, 0);
        step(1, 0, 4'h0, 0, 4'h0, 1, 0);

        // same-cycle write and accept uses old flags
        step(1, 1, 4'b0000, 0, 4'h0, 1, 0);
        step(1, 1, 4'b0010, 1, 4'd2, 1, 0); chk("cs_old", pass, 0);
        step(1, 0, 4'h0, 1, 4'd2, 1, 0);    chk("cs_new", pass, 1);

        // overflow counter saturation and clear priority
        for (int i = 0; i < 5; i++) step(1, 1, 4'b0001, 0, 4'h0, 1, 0);
`ifdef COND_FLAG_OVF_COUNT_EN
        chk("ovf_sat", ovf_count, CMAX);
`else
        chk("ovf_off", ovf_count, 0);
`endif
        step(1, 1, 4'b0001, 0, 4'h0, 1, 1);
        chk("ovf_clr", ovf_count, 0);

        // reset while FULL
        step(1, 1, 4'b0101, 0, 4'h0, 1, 0);
        step(1, 0, 4'h0, 1, 4'd0, 0, 0);
        step(0, 0, 4'h0, 0, 4'h0, 0, 0);
        chk("rst_full_valid", pass_valid, 0);
        chk("rst_full_flags", flags_q, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0), $urandom_range(0, 2) == 0, 4'($urandom),
                 $urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
